x3q16_mem_responder: RTL and testbench
======================================

# x3q16_mem_responder

Memory-side responder for the x3q16 core's single-outstanding request bus. It latches each `request` pulse from the core and services it against an internal word-addressed RAM after a fixed, parameterised latency. It returns read data with a one-cycle `memory_ready` pulse and confirms writes with a one-cycle `write_complete` pulse. It also flags writes into the protected high region on `memory_critical` and accepts image preload while the system is held in reset.

## Interface
Parameters:
- `DEPTH`, 1024: RAM words; array index = `request_address mod DEPTH`; power of two.
- `READ_LAT`, 2: edges from request sample to `memory_ready` rise; legal range 1..15.
- `WRITE_LAT`, 1: edges from request sample to `write_complete` rise; legal range 1..15.
- `CRIT_BASE`, 16'hFF00: writes to addresses `>= CRIT_BASE` are protected.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `request`  in  1  request strobe from core, sampled on posedge
- `request_type`  in  1  0 = read, 1 = write
- `request_address`  in  16  word address
- `data_out`  in  16  write data from core
- `ld_en`  in  1  preload write enable, honoured only while `reset` = 1
- `ld_addr`  in  16  preload address (mod DEPTH)
- `ld_data`  in  16  preload data
- `memory_in`  out  16  read data to core
- `memory_ready`  out  1  read-complete pulse
- `write_complete`  out  1  write-complete pulse
- `memory_critical`  out  1  protected-write pulse
- `req_overrun`  out  1  sticky: request arrived while busy

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE + `request`=1: latch type, address and data; load counter with LAT-1, where LAT = READ_LAT or WRITE_LAT by type. Go to WAIT, or directly to RESP if LAT-1 = 0.
- WAIT: decrement the counter each edge. At 0, go to RESP.
- RESP (one cycle):
  - Read: drive `memory_in` = RAM[addr] and `memory_ready` = 1.
  - Write: perform the RAM write on entry, unless addr ≥ CRIT_BASE. In that case suppress the write, still pulse `write_complete`, and pulse `memory_critical` in the same cycle.
  - Then return to IDLE.
- `request` seen in WAIT or RESP: dropped, `req_overrun` set. Only reset clears it. The in-flight transaction completes unchanged.
- IDLE→latch happens on the same edge the core's post-reset request (held high through reset) is first sampled. The fetch of address 0 therefore proceeds automatically.
- `memory_in` holds the last read data between reads; writes do not alter it.
- Preload: while `reset`=1, each edge with `ld_en`=1 writes RAM[ld_addr mod DEPTH] = ld_data. `ld_en` is ignored while `reset`=0. The RAM is never cleared by reset.

## Timing
- Reset values: `memory_in`=0, `memory_ready`=0, `write_complete`=0, `memory_critical`=0, `req_overrun`=0, FSM=IDLE.
- Request sampled at edge N:
  - Read: `memory_ready` is high for exactly the cycle following edge N+READ_LAT.
  - Write: `write_complete` (and `memory_critical` when protected) is high for exactly the cycle following edge N+WRITE_LAT. The RAM is updated at edge N+WRITE_LAT.
- Pulses are never longer than one cycle, because the core re-samples in its fetch stage.
- Earliest next accepted request: the edge that ends the RESP cycle (back-to-back allowed).
- Reset asserted mid-transaction: abort immediately, with no pulse. A write not yet committed is lost.
- Address ≥ DEPTH wraps through the low bits. Comparison against CRIT_BASE uses the full 16-bit address.

## Structure
- Shared package `x3q16_pkg`: request-type constants (REQ_READ=0, REQ_WRITE=1), FSM state encoding, default CRIT_BASE.
- Sub-module `x3q16_mem_array`: DEPTH×16 synchronous-read, single-write-port RAM. The write port is muxed between the preload path and the core path; the preload path is selected when `reset`=1. The read address is registered.
- Responder top: FSM, latency counter, latches, overrun flag. Target 150–250 lines.

## Test plan
- Preload 0x0000=0x1234 during reset; release reset with the core's request high, READ_LAT=2 → `memory_ready`=1 for one cycle, 2 edges after the first sample, with `memory_in`=0x1234.
- Write 0xBEEF to 0x0010, then read 0x0010 → `write_complete` pulse 1 edge after the write; read returns 0xBEEF.
- Write 0x5555 to 0xFF80 → `write_complete`=1 and `memory_critical`=1 in the same single cycle; a subsequent read of 0xFF80 returns the preloaded value, not 0x5555.
- Read 0x0400 with DEPTH=1024 → returns RAM[0x0000] (wrap).
- Second request one edge after the first (READ_LAT=3) → the first read completes normally, the second gets no response, `req_overrun`=1 until reset.
- Assert `reset` in WAIT during a write to 0x0020 → no `write_complete`; after reset, RAM[0x0020] is unchanged.

Source files
------------

// File: rtl/x3q16_pkg.sv
// Shared definitions for the x3q16 memory responder: request encodings,
// responder FSM states and the default protected-region base.
package x3q16_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [15:0] CRIT_BASE_DEFAULT = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload for a latency in 1..15 edges
    function automatic logic [3:0] lat_load(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/x3q16_mem_array.sv
// DEPTH x 16 RAM with a registered read address and one write port shared
// between the reset-time preload path and the responder's commit path.
module x3q16_mem_array
    import x3q16_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [15:0]   ld_data,
    input  logic          core_we,
    input  logic [AW-1:0] core_idx,
    input  logic [15:0]   core_wdata,
    input  logic [AW-1:0] rd_idx,
    output logic [15:0]   rd_data
);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx_q;
    logic          we;
    logic [AW-1:0] w_idx;
    logic [15:0]   w_data;

    // Preload owns the write port for as long as the system is held in reset
    always_comb begin
        we     = core_we;
        w_idx  = core_idx;
        w_data = core_wdata;
        if (reset) begin
            we     = ld_en;
            w_idx  = ld_idx;
            w_data = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_idx] <= w_data;
        end
        rd_idx_q <= rd_idx;
    end

    assign rd_data = mem[rd_idx_q];

endmodule

// File: rtl/x3q16_mem_responder.sv
// Single-outstanding memory responder: latches a core request, waits a fixed
// latency, then commits the read or write with a one-cycle completion pulse.
module x3q16_mem_responder
    import x3q16_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          READ_LAT  = 2,
    parameter int          WRITE_LAT = 1,
    parameter logic [15:0] CRIT_BASE = CRIT_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request,
    input  logic        request_type,
    input  logic [15:0] request_address,
    input  logic [15:0] data_out,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic [15:0] memory_in,
    output logic        memory_ready,
    output logic        write_complete,
    output logic        memory_critical,
    output logic        req_overrun
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] READ_LOAD  = lat_load(READ_LAT);
    localparam logic [3:0] WRITE_LOAD = lat_load(WRITE_LAT);

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          type_q;
    logic [15:0]   addr_q;
    logic [15:0]   data_q;
    logic          accept;
    logic          commit;
    logic          overrun_hit;
    logic [3:0]    load;
    logic          is_crit;
    logic          core_we;
    logic [AW-1:0] rd_idx;
    logic [15:0]   rd_data;
    logic          unused_ld_bits;

    assign load           = (request_type == REQ_WRITE) ? WRITE_LOAD : READ_LOAD;
    assign is_crit        = (addr_q >= CRIT_BASE);
    assign core_we        = commit && (type_q == REQ_WRITE) && !is_crit;
    assign unused_ld_bits = ^ld_addr[15:AW];

    // Point the RAM at the incoming address on the accept edge so a 1-edge
    // read latency still sees valid data at the commit edge
    assign rd_idx = accept ? request_address[AW-1:0] : addr_q[AW-1:0];

    x3q16_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .ld_en     (ld_en),
        .ld_idx    (ld_addr[AW-1:0]),
        .ld_data   (ld_data),
        .core_we   (core_we),
        .core_idx  (addr_q[AW-1:0]),
        .core_wdata(data_q),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // RESP is the commit cycle; the completion pulse shows in the cycle after
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        accept      = 1'b0;
        commit      = 1'b0;
        overrun_hit = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    accept     = 1'b1;
                    cnt_next   = load;
                    state_next = (load == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                overrun_hit = request;
                cnt_next    = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                overrun_hit = request;
                commit      = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q <= REQ_READ;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            type_q <= request_type;
            addr_q <= request_address;
            data_q <= data_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memory_in       <= '0;
            memory_ready    <= 1'b0;
            write_complete  <= 1'b0;
            memory_critical <= 1'b0;
            req_overrun     <= 1'b0;
        end else begin
            memory_ready    <= commit && (type_q == REQ_READ);
            write_complete  <= commit && (type_q == REQ_WRITE);
            memory_critical <= commit && (type_q == REQ_WRITE) && is_crit;
            req_overrun     <= req_overrun | overrun_hit;
            if (commit && (type_q == REQ_READ)) begin
                memory_in <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_x3q16_mem_responder.sv
// Scoreboard bench for x3q16_mem_responder: expected completions are queued at
// issue time and matched against the pulses the responder produces.
module tb_x3q16_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        request = 1'b0;
    logic        request_type = 1'b0;
    logic [15:0] request_address = '0;
    logic [15:0] data_out = '0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] memory_in;
    logic        memory_ready;
    logic        write_complete;
    logic        memory_critical;
    logic        req_overrun;

    typedef struct {
        bit          is_write;
        logic [15:0] data;
        bit          crit;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [15:0] mdl [1024];
    logic [15:0] last_read = '0;
    int          edge_count = 0;
    int          checks = 0;
    int          errors = 0;

    x3q16_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .request        (request),
        .request_type   (request_type),
        .request_address(request_address),
        .data_out       (data_out),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .memory_in      (memory_in),
        .memory_ready   (memory_ready),
        .write_complete (write_complete),
        .memory_critical(memory_critical),
        .req_overrun    (req_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Completion monitor: every pulse must match the oldest outstanding entry
    always @(negedge clk) begin
        if (!reset) begin
            if (memory_ready || write_complete) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'(sb.size()), 32'd1);
                end else begin
                    e_mon = sb.pop_front();
                    checkOutput("pulse_edge", 32'(edge_count), 32'(e_mon.due));
                    checkOutput("pulse_kind", {30'b0, memory_ready, write_complete},
                                e_mon.is_write ? 32'd1 : 32'd2);
                    checkOutput("critical", 32'(memory_critical), 32'(e_mon.crit));
                    if (!e_mon.is_write) last_read = e_mon.data;
                    checkOutput("memory_in", 32'(memory_in), 32'(last_read));
                end
            end else if (memory_critical) begin
                checkOutput("stray_critical", 32'(memory_critical), 32'd0);
            end
        end
    end

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        mdl[addr[9:0]] = data;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic pushExpect(input bit is_write, input logic [15:0] addr, input logic [15:0] data, input int due);
        exp_t e;
        e.is_write = is_write;
        e.crit     = is_write && (addr >= 16'hFF00);
        e.due      = due;
        e.data     = is_write ? 16'h0 : mdl[addr[9:0]];
        if (is_write && !e.crit) mdl[addr[9:0]] = data;
        sb.push_back(e);
    endtask

    // Returns in the pulse cycle of the last completion, so a following
    // request is sampled on the edge that ends it
    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        if (sb.size() != 0) begin
            checkOutput(tag, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input bit is_write, input logic [15:0] addr, input logic [15:0] data);
        int n_edge;
        request         = 1'b1;
        request_type    = is_write;
        request_address = addr;
        data_out        = data;
        n_edge          = edge_count + 1;
        pushExpect(is_write, addr, data, n_edge + (is_write ? 1 : 2));
        @(posedge clk);
        #1 request = 1'b0;
        waitDrain("drain_timeout");
    endtask

    initial begin
        logic [15:0] d;
        int n_edge;

        preload(16'h0000, 16'h1234);
        preload(16'hFF80, 16'hA5A5);
        preload(16'h0020, 16'h7777);
        preload(16'h0030, 16'h1111);
        preload(16'h0010, 16'h0F0F);

        @(negedge clk);
        checkOutput("rst_memory_in", 32'(memory_in), 32'h0);
        checkOutput("rst_ready", 32'(memory_ready), 32'h0);
        checkOutput("rst_wc", 32'(write_complete), 32'h0);
        checkOutput("rst_crit", 32'(memory_critical), 32'h0);
        checkOutput("rst_overrun", 32'(req_overrun), 32'h0);

        // Core holds its fetch of address 0 through reset release
        request         = 1'b1;
        request_type    = 1'b0;
        request_address = 16'h0000;
        #1 reset = 1'b0;
        n_edge = edge_count + 1;
        pushExpect(1'b0, 16'h0000, 16'h0, n_edge + 2);
        @(posedge clk);
        #1 request = 1'b0;
        waitDrain("boot_fetch_timeout");

        applyStimulus(1'b1, 16'h0010, 16'hBEEF);
        applyStimulus(1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 16'hFF80, 16'h5555);
        applyStimulus(1'b0, 16'hFF80, 16'h0000);
        applyStimulus(1'b0, 16'h0400, 16'h0000);

        // Preload enable must be ignored outside reset
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 16'h0030;
        ld_data = 16'hDEAD;
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        #1 applyStimulus(1'b0, 16'h0030, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            applyStimulus(1'b1, 16'h0100 + 16'(i), d);
            applyStimulus(1'b0, 16'h0500 + 16'(i), 16'h0000);
        end
        checkOutput("overrun_clear", 32'(req_overrun), 32'h0);

        // Second request one edge into a read must be dropped
        request         = 1'b1;
        request_type    = 1'b0;
        request_address = 16'h0010;
        n_edge = edge_count + 1;
        pushExpect(1'b0, 16'h0010, 16'h0, n_edge + 2);
        @(posedge clk);
        #1 request_address = 16'h0020;
        @(posedge clk);
        #1 request = 1'b0;
        waitDrain("overrun_timeout");
        repeat (4) @(negedge clk);
        checkOutput("overrun_set", 32'(req_overrun), 32'h1);
        #1 applyStimulus(1'b0, 16'h0000, 16'h0000);
        checkOutput("overrun_sticky", 32'(req_overrun), 32'h1);

        // Reset before the commit edge aborts the write
        request         = 1'b1;
        request_type    = 1'b1;
        request_address = 16'h0020;
        data_out        = 16'h9999;
        @(posedge clk);
        #1 reset = 1'b1;
        request = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("abort_wc", 32'(write_complete), 32'h0);
        checkOutput("abort_overrun_cleared", 32'(req_overrun), 32'h0);
        last_read = 16'h0;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 applyStimulus(1'b0, 16'h0020, 16'h0000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
